// File: rtl/enc_pkg.sv
// Shared types and Gray-sequence decode helper for the quadrature encoder bank.
package enc_pkg;

    typedef logic [1:0] enc_ab_t;

    typedef struct packed {
        logic              err;
        logic signed [1:0] step;
    } enc_delta_t;

    localparam enc_ab_t ENC_IDLE = 2'b11;

    // Indexed by the current {A,B}; yields the next state in the CW direction.
    localparam enc_ab_t ENC_CW_NEXT [4] = '{2'b01, 2'b11, 2'b00, 2'b10};

    function automatic enc_delta_t enc_delta(input enc_ab_t prev, input enc_ab_t cur);
        enc_delta_t d;
        d.err  = 1'b0;
        d.step = 2'sb00;
        if (cur == ENC_CW_NEXT[prev]) begin
            d.step = 2'sb01;
        end else if (prev == ENC_CW_NEXT[cur]) begin
            d.step = 2'sb11;
        end else if (cur != prev) begin
            d.err = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: 2-FF synchroniser, tick-based debounce, Gray decode,
// detent sub-count and saturating or wrapping position register.
module enc_channel
    import enc_pkg::*;
#(
    parameter int W       = 8,
    parameter int MAX_VAL = 255,
    parameter int RST_VAL = 0,
    parameter int STEP    = 1,
    parameter int DIV     = 4,
    parameter int DB_CNT  = 4,
    parameter int WRAP    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick,
    input  logic         i_a,
    input  logic         i_b,
    input  logic         i_zero,
    output logic [W-1:0] o_pos,
    output logic         o_step_pulse,
    output logic         o_dir,
    output logic         o_err
);

    localparam logic [W:0]        C_MAX  = (W+1)'(MAX_VAL);
    localparam logic [W:0]        C_STEP = (W+1)'(STEP);
    localparam logic [W:0]        C_MOD  = (W+1)'(MAX_VAL + 1);
    localparam logic [W-1:0]      C_RST  = W'(RST_VAL);
    localparam logic [3:0]        C_DB   = 4'(DB_CNT - 1);
    localparam logic signed [3:0] C_DIV  = 4'(DIV);
    localparam logic signed [3:0] C_NDIV = -C_DIV;

    enc_ab_t           r_sync1, r_sync2, r_db, r_prev;
    logic [3:0]        r_cnt [2];
    logic signed [3:0] r_sub;
    logic              r_up, r_dn, r_err;
    logic [W-1:0]      r_pos;
    logic              r_step_pulse, r_dir;

    enc_delta_t        w_d;
    logic signed [3:0] w_sub_nxt;
    logic [W:0]        w_pos_ext, w_up_sum;
    logic [W-1:0]      w_pos_nxt;

    // Synchronise and debounce; bit 1 is A, bit 0 is B.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= ENC_IDLE;
            r_sync2 <= ENC_IDLE;
            r_db    <= ENC_IDLE;
            for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
        end else begin
            // NOTE: all sequential state uses <= so every flop samples pre-edge values.
            r_sync1 <= {i_a, i_b};
            r_sync2 <= r_sync1;
            if (i_tick) begin
                for (int k = 0; k < 2; k++) begin
                    if (r_sync2[k] != r_db[k]) begin
                        if (r_cnt[k] == C_DB) begin
                            r_db[k]  <= r_sync2[k];
                            r_cnt[k] <= '0;
                        end else begin
                            r_cnt[k] <= r_cnt[k] + 4'd1;
                        end
                    end else begin
                        r_cnt[k] <= '0;
                    end
                end
            end
        end
    end

    assign w_d       = enc_delta(r_prev, r_db);
    assign w_sub_nxt = r_sub + {{2{w_d.step[1]}}, w_d.step};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= ENC_IDLE;
            r_sub  <= '0;
            r_up   <= 1'b0;
            r_dn   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_prev <= r_db;
            r_up   <= 1'b0;
            r_dn   <= 1'b0;
            r_err  <= w_d.err;
            if (i_zero) begin
                r_sub <= '0;
            end else if (!w_d.err) begin
                if (w_sub_nxt == C_DIV) begin
                    r_up  <= 1'b1;
                    r_sub <= '0;
                end else if (w_sub_nxt == C_NDIV) begin
                    r_dn  <= 1'b1;
                    r_sub <= '0;
                end else begin
                    r_sub <= w_sub_nxt;
                end
            end
        end
    end

    assign w_pos_ext = {1'b0, r_pos};
    assign w_up_sum  = w_pos_ext + C_STEP;

    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        w_pos_nxt = r_pos;
        if (r_up) begin
            if (w_up_sum > C_MAX) w_pos_nxt = (WRAP != 0) ? W'(w_up_sum - C_MOD) : W'(C_MAX);
            else                  w_pos_nxt = W'(w_up_sum);
        end else if (r_dn) begin
            if (w_pos_ext < C_STEP) w_pos_nxt = (WRAP != 0) ? W'(w_pos_ext + C_MOD - C_STEP) : '0;
            else                    w_pos_nxt = W'(w_pos_ext - C_STEP);
        end
    end

    // A zero request wins over a detent landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pos        <= C_RST;
            r_step_pulse <= 1'b0;
            r_dir        <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            if (i_zero) begin
                r_pos <= C_RST;
            end else if (r_up || r_dn) begin
                r_dir        <= r_up;
                r_pos        <= w_pos_nxt;
                r_step_pulse <= (w_pos_nxt != r_pos);
            end
        end
    end

    assign o_pos        = r_pos;
    assign o_step_pulse = r_step_pulse;
    assign o_dir        = r_dir;
    assign o_err        = r_err;

endmodule

// File: rtl/quad_encoder_bank.sv
// N-channel quadrature encoder front end: independent channels, packed position bus.
module quad_encoder_bank #(
    parameter int N_CH    = 2,
    parameter int W       = 8,
    parameter int MAX_VAL = 255,
    parameter int RST_VAL = 0,
    parameter int STEP    = 1,
    parameter int DIV     = 4,
    parameter int DB_CNT  = 4,
    parameter int WRAP    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [N_CH-1:0]   enc_a,
    input  logic [N_CH-1:0]   enc_b,
    input  logic [N_CH-1:0]   zero,
    output logic [N_CH*W-1:0] pos,
    output logic [N_CH-1:0]   step_pulse,
    output logic [N_CH-1:0]   dir,
    output logic [N_CH-1:0]   err
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        enc_channel #(
            .W       (W),
            .MAX_VAL (MAX_VAL),
            .RST_VAL (RST_VAL),
            .STEP    (STEP),
            .DIV     (DIV),
            .DB_CNT  (DB_CNT),
            .WRAP    (WRAP)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_tick       (tick),
            .i_a          (enc_a[g]),
            .i_b          (enc_b[g]),
            .i_zero       (zero[g]),
            .o_pos        (pos[g*W +: W]),
            .o_step_pulse (step_pulse[g]),
            .o_dir        (dir[g]),
            .o_err        (err[g])
        );
    end

endmodule
